// File: rtl/alu_seq_pkg.sv
// ---------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the byte-serial ALU sequencer:
//   op_t        - request operation codes (codes 6 and 7 execute as ADD)
//   ALU_*       - function codes understood by the 8-bit combinational ALU
//   state_t     - sequencer FSM states
//   decode_op   - maps a raw 3-bit request code onto op_t
// No ports (package).
// ---------------------------------------------------------------------------
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_NAND = 3'd5
  } op_t;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_ADC  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_SBC  = 3'b011;
  localparam logic [2:0] ALU_AND  = 3'b100;
  localparam logic [2:0] ALU_OR   = 3'b101;
  localparam logic [2:0] ALU_XOR  = 3'b110;
  localparam logic [2:0] ALU_NAND = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Unused codes 6 and 7 fall back to ADD.
  function automatic op_t decode_op(input logic [2:0] code);
    op_t op;
    case (code)
      3'd1:    op = OP_SUB;
      3'd2:    op = OP_AND;
      3'd3:    op = OP_OR;
      3'd4:    op = OP_XOR;
      3'd5:    op = OP_NAND;
      default: op = OP_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_seq_ctrl.sv
// ---------------------------------------------------------------------------
// alu_seq_ctrl
// Runs one NBYTES x 8-bit arithmetic/logic operation at a time on an external
// 8-bit combinational ALU, one byte per cycle LSB first, chaining carries.
//
// Optional feature: define ALU_SEQ_OVF_EN to add the rsp_ovf port and the
// signed-overflow flag. Without it the port and logic are absent.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid/req_ready    request handshake (ready only while idle)
//   req_op, req_a, req_b   operation code and W-bit operands
//   rsp_valid/rsp_ready    response handshake
//   rsp_result             W-bit result
//   rsp_carry              ADD carry out / SUB borrow / 0 for logic ops
//   rsp_zero               result is all zeros
//   rsp_ovf                signed overflow (ALU_SEQ_OVF_EN only)
//   alu_fun/a/b/cin        drive to the ALU instance
//   alu_out/cout/zero      combinational ALU results
// ---------------------------------------------------------------------------
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_op,
  input  logic [8*NBYTES-1:0]   req_a,
  input  logic [8*NBYTES-1:0]   req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [8*NBYTES-1:0]   rsp_result,
  output logic                  rsp_carry,
  output logic                  rsp_zero,
  output logic [2:0]            alu_fun,
  output logic [7:0]            alu_a,
  output logic [7:0]            alu_b,
  output logic                  alu_cin,
  input  logic [7:0]            alu_out,
  input  logic                  alu_cout,
  input  logic                  alu_zero
`ifdef ALU_SEQ_OVF_EN
  ,
  output logic                  rsp_ovf
`endif
);

  localparam int W     = 8 * NBYTES;
  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  op_t              r_op;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_result;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry;
  logic             r_zacc;

  logic             w_accept;
  logic             w_done;
  logic             w_first;
  logic             w_last;
  logic [7:0]       w_a_byte;
  logic [7:0]       w_b_byte;

  assign w_accept = (r_state == ST_IDLE) && req_valid;
  assign w_done   = (r_state == ST_DONE);
  assign w_first  = (r_idx == '0);
  assign w_last   = (r_idx == LAST_IDX);
  assign w_a_byte = r_a[{r_idx, 3'b000} +: 8];
  assign w_b_byte = r_b[{r_idx, 3'b000} +: 8];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state, handshakes and ALU drive
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    alu_fun     = ALU_ADD;
    alu_a       = 8'h00;
    alu_b       = 8'h00;
    alu_cin     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        alu_a = w_a_byte;
        alu_b = w_b_byte;
        case (r_op)
          OP_ADD: begin
            alu_fun = w_first ? ALU_ADD : ALU_ADC;
            alu_cin = w_first ? 1'b0 : r_carry;
          end
          // b is stored inverted; the +1 of two's complement enters as cin
          OP_SUB: begin
            alu_fun = ALU_ADC;
            alu_cin = w_first ? 1'b1 : r_carry;
          end
          OP_AND:  alu_fun = ALU_AND;
          OP_OR:   alu_fun = ALU_OR;
          OP_XOR:  alu_fun = ALU_XOR;
          OP_NAND: alu_fun = ALU_NAND;
          default: alu_fun = ALU_ADD;
        endcase
        if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Control registers: byte index, carry chain and zero accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op    <= OP_ADD;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_zacc  <= 1'b0;
    end else if (w_accept) begin
      r_op    <= decode_op(req_op);
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_zacc  <= 1'b1;
    end else if (r_state == ST_RUN) begin
      r_carry <= alu_cout;
      r_zacc  <= r_zacc & alu_zero;
      r_idx   <= w_last ? '0 : r_idx + 1'b1;
    end
  end

  // Operand and result storage (data only; outputs are gated by state)
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a <= req_a;
      r_b <= (decode_op(req_op) == OP_SUB) ? ~req_b : req_b;
    end else if (r_state == ST_RUN) begin
      r_result[{r_idx, 3'b000} +: 8] <= alu_out;
    end
  end

  // Response outputs read zero outside DONE so reset/idle values are defined
  assign rsp_result = w_done ? r_result : '0;
  assign rsp_zero   = w_done & r_zacc;

  // SUB reports borrow, which is the inverse of the a + ~b + 1 carry
  always_comb begin
    rsp_carry = 1'b0;
    if (w_done) begin
      if (r_op == OP_ADD)      rsp_carry = r_carry;
      else if (r_op == OP_SUB) rsp_carry = ~r_carry;
    end
  end

`ifdef ALU_SEQ_OVF_EN
  logic w_arith;
  assign w_arith = (r_op == OP_ADD) || (r_op == OP_SUB);
  // r_b already holds ~b for SUB, so one rule covers both operations
  assign rsp_ovf = w_done && w_arith && (r_a[W-1] == r_b[W-1]) &&
                   (r_result[W-1] != r_a[W-1]);
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
module tb_alu_seq_ctrl;

  localparam int NB = 4;
  localparam int W  = 8 * NB;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [2:0]   req_op = 3'd0;
  logic [W-1:0] req_a = '0;
  logic [W-1:0] req_b = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [W-1:0] rsp_result;
  logic         rsp_carry;
  logic         rsp_zero;
  logic [2:0]   alu_fun;
  logic [7:0]   alu_a;
  logic [7:0]   alu_b;
  logic         alu_cin;
  logic [7:0]   alu_out;
  logic         alu_cout;
  logic         alu_zero;
`ifdef ALU_SEQ_OVF_EN
  logic         rsp_ovf;
`endif
  logic         last_ovf = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl #(.NBYTES(NB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_zero   (rsp_zero),
    .alu_fun    (alu_fun),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_cin    (alu_cin),
    .alu_out    (alu_out),
    .alu_cout   (alu_cout),
    .alu_zero   (alu_zero)
`ifdef ALU_SEQ_OVF_EN
    ,
    .rsp_ovf    (rsp_ovf)
`endif
  );

  // Behavioural 8-bit combinational ALU
  logic [8:0] alu_t;
  always_comb begin
    alu_t = '0;
    case (alu_fun)
      3'd0:    alu_t = {1'b0, alu_a} + {1'b0, alu_b};
      3'd1:    alu_t = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
      3'd2:    alu_t = {1'b0, alu_a} - {1'b0, alu_b};
      3'd3:    alu_t = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, ~alu_cin};
      3'd4:    alu_t = {1'b0, alu_a & alu_b};
      3'd5:    alu_t = {1'b0, alu_a | alu_b};
      3'd6:    alu_t = {1'b0, alu_a ^ alu_b};
      default: alu_t = {1'b0, ~(alu_a & alu_b)};
    endcase
    alu_out  = alu_t[7:0];
    alu_cout = alu_t[8];
    alu_zero = (alu_t[7:0] == 8'h00);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Full-width reference for one operation
  typedef struct packed {
    logic [W-1:0] res;
    logic         c;
    logic         z;
    logic         v;
  } exp_t;

  function automatic exp_t ref_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t         e;
    logic [W:0]   s;
    logic [W-1:0] bp;
    e  = '0;
    bp = b;
    case (op)
      3'd1: begin
        e.res = a - b;
        e.c   = (a < b);
        bp    = ~b;
      end
      3'd2: e.res = a & b;
      3'd3: e.res = a | b;
      3'd4: e.res = a ^ b;
      3'd5: e.res = ~(a & b);
      default: begin
        s     = {1'b0, a} + {1'b0, b};
        e.res = s[W-1:0];
        e.c   = s[W];
      end
    endcase
    e.z = (e.res == '0);
    e.v = (op <= 3'd1) && (a[W-1] == bp[W-1]) && (e.res[W-1] != a[W-1]);
    return e;
  endfunction

  // Transaction model: phase 0 idle, 1..NB processing byte phase-1, NB+1 done
  int           m_phase = 0;
  logic [2:0]   m_op = 3'd0;
  logic [W-1:0] m_a = '0;
  logic [W-1:0] m_b = '0;
  exp_t         m_exp = '0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_phase = 0;
    end else if (m_phase == 0) begin
      if (req_valid) begin
        m_op    = (req_op > 3'd5) ? 3'd0 : req_op;
        m_a     = req_a;
        m_b     = req_b;
        m_exp   = ref_op(m_op, m_a, m_b);
        m_phase = 1;
      end
    end else if (m_phase <= NB) begin
      m_phase++;
    end else if (rsp_ready) begin
      m_phase = 0;
    end
  end

  task automatic cmp_cycle();
    int          k;
    logic [63:0] mask;
    logic [63:0] a64;
    logic [63:0] b64;
    logic [63:0] cin64;
    logic [2:0]  efun;
    if (!rst_n) begin
      chk("rst_req_ready", 64'(req_ready), 64'd1);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      chk("rst_result", 64'(rsp_result), 64'd0);
      chk("rst_carry", 64'(rsp_carry), 64'd0);
      chk("rst_zero", 64'(rsp_zero), 64'd0);
      chk("rst_alu_drive", 64'({alu_fun, alu_a, alu_b, alu_cin}), 64'd0);
    end else begin
      chk("req_ready", 64'(req_ready), 64'(m_phase == 0));
      chk("rsp_valid", 64'(rsp_valid), 64'(m_phase == NB + 1));
      if (m_phase == NB + 1) begin
        chk("rsp_result", 64'(rsp_result), 64'(m_exp.res));
        chk("rsp_carry", 64'(rsp_carry), 64'(m_exp.c));
        chk("rsp_zero", 64'(rsp_zero), 64'(m_exp.z));
`ifdef ALU_SEQ_OVF_EN
        chk("rsp_ovf", 64'(rsp_ovf), 64'(m_exp.v));
`endif
      end
      if (m_phase >= 1 && m_phase <= NB) begin
        k    = m_phase - 1;
        mask = (64'd1 << (8 * k)) - 64'd1;
        a64  = 64'(m_a);
        b64  = (m_op == 3'd1) ? 64'(~m_b) : 64'(m_b);
        case (m_op)
          3'd0: begin
            efun  = (k == 0) ? 3'b000 : 3'b001;
            cin64 = ((a64 & mask) + (b64 & mask)) >> (8 * k);
          end
          3'd1: begin
            efun  = 3'b001;
            cin64 = ((a64 & mask) + (b64 & mask) + 64'd1) >> (8 * k);
          end
          default: begin
            efun  = m_op + 3'd2;
            cin64 = 64'd0;
          end
        endcase
        chk("alu_a", 64'(alu_a), (a64 >> (8 * k)) & 64'hFF);
        chk("alu_b", 64'(alu_b), (b64 >> (8 * k)) & 64'hFF);
        chk("alu_fun", 64'(alu_fun), 64'(efun));
        chk("alu_cin", 64'(alu_cin), cin64);
      end else begin
        chk("alu_idle_drive", 64'({alu_fun, alu_a, alu_b, alu_cin}), 64'd0);
      end
    end
  endtask

  initial begin
    @(negedge rst_n);
    forever begin
      @(negedge clk);
      cmp_cycle();
    end
  end

  task automatic wait_rsp(input string nm);
    int n;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_latency"}, 64'(n), 64'(NB));
`ifdef ALU_SEQ_OVF_EN
    last_ovf = rsp_ovf;
`endif
  endtask

  task automatic do_op(input string nm, input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] er, input logic ec,
                       input logic ez);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    rsp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_req_ready"}, 64'(req_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    wait_rsp(nm);
    chk({nm, "_result"}, 64'(rsp_result), 64'(er));
    chk({nm, "_carry"}, 64'(rsp_carry), 64'(ec));
    chk({nm, "_zero"}, 64'(rsp_zero), 64'(ez));
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({nm, "_idle_after"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_req_ready", 64'(req_ready), 64'd1);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);

    do_op("add_ff_1",   3'd0, 32'h000000FF, 32'h00000001, 32'h00000100, 1'b0, 1'b0);
    do_op("add_wrap",   3'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1);
    do_op("sub_equal",  3'd1, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 1'b1);
    do_op("sub_borrow", 3'd1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b1, 1'b0);
    do_op("nand",       3'd5, 32'hFFFF0000, 32'hFF00FF00, 32'h00FFFFFF, 1'b0, 1'b0);
    do_op("and",        3'd2, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0);
    do_op("or_zero",    3'd3, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b1);
    do_op("xor",        3'd4, 32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF, 1'b0, 1'b0);
    do_op("op7_add",    3'd7, 32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 1'b0);
    do_op("op6_add",    3'd6, 32'h00FF00FF, 32'h00010001, 32'h01000100, 1'b0, 1'b0);

    // Back-pressure in DONE with a second request pending
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 3'd0;
    req_a     = 32'h00000010;
    req_b     = 32'h00000020;
    rsp_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_op = 3'd4;
    req_a  = 32'hAAAAAAAA;
    req_b  = 32'h55555555;
    wait_rsp("stall");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_result", 64'(rsp_result), 64'h30);
      chk("stall_valid", 64'(rsp_valid), 64'd1);
      chk("stall_req_ready", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("stall_idle_after", 64'(req_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("second_busy", 64'(req_ready), 64'd0);
    wait_rsp("second");
    chk("second_result", 64'(rsp_result), 64'hFFFFFFFF);
    chk("second_carry", 64'(rsp_carry), 64'd0);
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;

    // Reset in the middle of RUN
    req_valid = 1'b1;
    req_op    = 3'd0;
    req_a     = 32'h01010101;
    req_b     = 32'h01010101;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_req_ready", 64'(req_ready), 64'd1);
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_result", 64'(rsp_result), 64'd0);
    chk("midrst_flags", 64'({rsp_carry, rsp_zero}), 64'd0);
    chk("midrst_alu", 64'({alu_fun, alu_a, alu_b, alu_cin}), 64'd0);
`ifdef ALU_SEQ_OVF_EN
    chk("midrst_ovf", 64'(rsp_ovf), 64'd0);
`endif
    @(negedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midrst_no_rsp", 64'(rsp_valid), 64'd0);
    end
    do_op("after_rst", 3'd0, 32'h01010101, 32'h01010101, 32'h02020202, 1'b0, 1'b0);

`ifdef ALU_SEQ_OVF_EN
    do_op("ovf_add", 3'd0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0);
    chk("ovf_add_flag", 64'(last_ovf), 64'd1);
    do_op("ovf_sub", 3'd1, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b0);
    chk("ovf_sub_flag", 64'(last_ovf), 64'd1);
    do_op("ovf_none", 3'd0, 32'h00000001, 32'h00000001, 32'h00000002, 1'b0, 1'b0);
    chk("ovf_none_flag", 64'(last_ovf), 64'd0);
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
